// File: rtl/mpu6050_i2c_responder.sv
// MPU6050-style I2C target: PWR_MGMT_1, WHO_AM_I and a 14-byte sensor block.
// SCL/SDA are oversampled on clk; SDA is driven open-drain (0 or Z).
module mpu6050_i2c_responder #(
  parameter logic [6:0] DEV_ADDR     = 7'h68,
  parameter logic [7:0] WHO_AM_I_VAL = 8'h68,
  parameter logic [7:0] PWR_RST_VAL  = 8'h40
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         scl,
  inout  wire          sda,
  input  logic [111:0] sensor_data,
  output logic [7:0]   pwr_mgmt_1,
  output logic         sleep,
  output logic         wr_strobe,
  output logic         busy
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK,
    WR_DATA, WR_ACK, RD_DATA, RD_ACK
  } state_t;

  state_t state_q, state_d;
  logic [2:0]   scl_q, sda_q;
  logic [3:0]   cnt_q, cnt_d;
  logic [7:0]   shift_q, shift_d;
  logic [7:0]   ptr_q, ptr_d;
  logic [7:0]   pwr_q, pwr_d;
  logic [111:0] snap_q, snap_d;
  logic         oe_q, oe_d;
  logic         busy_q, busy_d;
  logic         wr_strobe_q, wr_strobe_d;

  logic scl_s, sda_s, scl_rise, scl_fall;
  logic start_det, stop_det;
  logic [7:0] rd_byte;
  logic [3:0] idx;
  logic [6:0] sh;

  // [0],[1] form the synchronizer; [2] is the previous value for edges
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_q <= 3'b111;
      sda_q <= 3'b111;
    end else begin
      scl_q <= {scl_q[1:0], scl};
      sda_q <= {sda_q[1:0], sda};
    end
  end

  assign scl_s     = scl_q[1];
  assign sda_s     = sda_q[1];
  assign scl_rise  = scl_s & ~scl_q[2];
  assign scl_fall  = ~scl_s & scl_q[2];
  assign start_det = scl_s & scl_q[2] & sda_q[2] & ~sda_s;
  assign stop_det  = scl_s & scl_q[2] & ~sda_q[2] & sda_s;

  // Low nibble minus 0xB maps 0x3B..0x48 onto byte index 0..13
  assign idx = ptr_q[3:0] - 4'hB;
  assign sh  = {idx, 3'b000};

  always_comb begin
    rd_byte = 8'h00;
    if (ptr_q == 8'h6B)
      rd_byte = pwr_q;
    else if (ptr_q == 8'h75)
      rd_byte = WHO_AM_I_VAL;
    else if (ptr_q >= 8'h3B && ptr_q <= 8'h48)
      rd_byte = 8'(snap_q >> (7'd104 - sh));
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    ptr_d       = ptr_q;
    pwr_d       = pwr_q;
    snap_d      = snap_q;
    oe_d        = oe_q;
    busy_d      = busy_q;
    wr_strobe_d = 1'b0;
    if (stop_det) begin
      state_d = IDLE;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else if (start_det) begin
      state_d = ADDR;
      cnt_d   = 4'd0;
      oe_d    = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: ;
        ADDR, PTR, WR_DATA: begin
          if (scl_rise) begin
            shift_d = {shift_q[6:0], sda_s};
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              cnt_d = 4'd0;
              if (state_q == ADDR)
                state_d = ADDR_ACK;
              else if (state_q == PTR)
                state_d = PTR_ACK;
              else
                state_d = WR_ACK;
            end
          end
        end
        // cnt 0: first fall starts the 9th bit, cnt 1: second fall ends it
        ADDR_ACK: begin
          if (scl_fall) begin
            if (cnt_q == 4'd0) begin
              if (shift_q[7:1] == DEV_ADDR) begin
                oe_d   = 1'b1;
                busy_d = 1'b1;
                cnt_d  = 4'd1;
                if (shift_q[0])
                  snap_d = sensor_data;
              end else begin
                state_d = IDLE;
                busy_d  = 1'b0;
              end
            end else begin
              cnt_d = 4'd0;
              if (shift_q[0]) begin
                state_d = RD_DATA;
                oe_d    = ~rd_byte[7];
              end else begin
                state_d = PTR;
                oe_d    = 1'b0;
              end
            end
          end
        end
        PTR_ACK: begin
          if (scl_fall) begin
            if (cnt_q == 4'd0) begin
              oe_d  = 1'b1;
              ptr_d = shift_q;
              cnt_d = 4'd1;
            end else begin
              oe_d    = 1'b0;
              cnt_d   = 4'd0;
              state_d = WR_DATA;
            end
          end
        end
        WR_ACK: begin
          if (scl_fall) begin
            if (cnt_q == 4'd0) begin
              oe_d  = 1'b1;
              cnt_d = 4'd1;
            end else begin
              oe_d    = 1'b0;
              cnt_d   = 4'd0;
              state_d = WR_DATA;
              ptr_d   = ptr_q + 8'd1;
              if (ptr_q == 8'h6B) begin
                pwr_d       = shift_q;
                wr_strobe_d = 1'b1;
              end
            end
          end
        end
        RD_DATA: begin
          if (scl_rise) begin
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              oe_d    = 1'b0;
              cnt_d   = 4'd0;
              state_d = RD_ACK;
            end else begin
              oe_d = ~rd_byte[3'd7 - cnt_q[2:0]];
            end
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            if (sda_s) begin
              state_d = IDLE;
              busy_d  = 1'b0;
            end else begin
              ptr_d = ptr_q + 8'd1;
              cnt_d = 4'd1;
            end
          end else if (scl_fall && cnt_q == 4'd1) begin
            state_d = RD_DATA;
            cnt_d   = 4'd0;
            oe_d    = ~rd_byte[7];
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      shift_q     <= 8'h00;
      ptr_q       <= 8'h00;
      pwr_q       <= PWR_RST_VAL;
      snap_q      <= '0;
      oe_q        <= 1'b0;
      busy_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      ptr_q       <= ptr_d;
      pwr_q       <= pwr_d;
      snap_q      <= snap_d;
      oe_q        <= oe_d;
      busy_q      <= busy_d;
      wr_strobe_q <= wr_strobe_d;
    end
  end

  assign sda        = oe_q ? 1'b0 : 1'bz;
  assign pwr_mgmt_1 = pwr_q;
  assign sleep      = pwr_q[6];
  assign wr_strobe  = wr_strobe_q;
  assign busy       = busy_q;

endmodule

// File: doc/mpu6050_i2c_responder.md
Name: mpu6050_i2c_responder

Overview:
- Synthesizable I2C target that models the MPU6050 register interface at 7-bit address 0x68.
- Answers the initiator-side init/read traffic our I2C master generates. Used as an on-chip loopback target and a bench DUT partner.
- Holds PWR_MGMT_1, a read-only WHO_AM_I, and a 14-byte sensor block (0x3B–0x48) sourced from a parallel input.
- Oversamples SCL/SDA on the system clock; SDA is open-drain.

Parameters:
- DEV_ADDR, 7'h68, 7-bit target address matched in the address byte.
- WHO_AM_I_VAL, 8'h68, value returned for register 0x75.
- PWR_RST_VAL, 8'h40, reset value of PWR_MGMT_1 (bit 6 = SLEEP).

Ports:
- clk  input  1  system clock, at least 16x SCL frequency.
- rst  input  1  asynchronous, active-high reset.
- scl  input  1  I2C clock from the master.
- sda  inout  1  I2C data; this block drives only 0 or Z.
- sensor_data  input  112  accel/temp/gyro bytes; register 0x3B = bits [111:104], 0x48 = bits [7:0].
- pwr_mgmt_1  output  8  current PWR_MGMT_1 contents.
- sleep  output  1  equals pwr_mgmt_1[6].
- wr_strobe  output  1  one-cycle pulse when any mapped register is written.
- busy  output  1  high from an address match until STOP or NACK.

Behaviour:
- **Reset:**
  - state = IDLE, SDA released (Z), pwr_mgmt_1 = PWR_RST_VAL, sleep = 1, wr_strobe = 0, busy = 0, register pointer = 0x00.
  - Reset asserted mid-transaction releases SDA asynchronously.
- **Input conditioning:**
  - scl and sda each pass through a 2-flop synchronizer, then an edge detector on the synchronized values.
  - START = synchronized SDA falls while SCL is high. STOP = SDA rises while SCL is high.
- **Bit timing:**
  - Sample SDA on the detected SCL rising edge.
  - Change the SDA drive on the clk edge after a detected SCL falling edge; this is 3 clk cycles after the pin edge.
- **States:**
  - IDLE: wait for START.
  - ADDR: shift 8 bits, MSB first.
  - ADDR_ACK: if addr[7:1] == DEV_ADDR, drive 0 for the 9th bit, else go to IDLE without driving. R/W = 0 goes to PTR. R/W = 1 captures sensor_data into a snapshot register and goes to RD_DATA.
  - PTR: shift 8 bits into the pointer.
  - PTR_ACK: drive ACK, then go to WR_DATA.
  - WR_DATA: shift 8 bits.
  - WR_ACK: always ACK. Commit the byte at the ACK falling edge, then increment the pointer and return to WR_DATA.
  - RD_DATA: drive 8 bits from the pointer target MSB first; a 1 bit means release the line.
  - RD_ACK: release SDA and sample the master's ACK. ACK = 0 increments the pointer and returns to RD_DATA. NACK goes to IDLE.
- **Overrides:**
  - START in any state, including repeated START, goes to ADDR and releases SDA.
  - STOP in any state goes to IDLE and releases SDA.
  - The pointer is preserved across transactions, so a repeated-start read continues from the last written pointer.
- **Register map:**
  - 0x6B is R/W (PWR_MGMT_1).
  - 0x75 is RO (WHO_AM_I_VAL).
  - 0x3B–0x48 are RO and read from the snapshot, so the 14 bytes are coherent within one read transaction.
  - All other addresses read 0x00; writes to them are ACKed and ignored (no wr_strobe).
  - Writes to RO registers are ignored with no wr_strobe.
- **Pointer:** 8-bit, increments by 1 after each data byte and wraps 0xFF→0x00.
- **busy:** set at a matching ADDR_ACK; cleared on STOP, NACK, or a non-matching address.

Test Plan:
- Reset, then write 0xD0 0x6B 0x00 and STOP → three ACKs, pwr_mgmt_1 = 0x00, sleep = 0, exactly one wr_strobe pulse.
- Write 0xD0 0x75, repeated START, 0xD1, read one byte with NACK → returns 0x68; SDA released after the 9th bit; busy falls.
- sensor_data = bytes 0x01..0x0E; write pointer 0x3B, read 14 bytes (ACK ×13, NACK) → 0x01..0x0E in order. Changing sensor_data mid-read does not alter the returned bytes.
- Address byte 0xA0 → no ACK (SDA stays Z for all 9 bits), busy stays 0, registers unchanged.
- Set pointer 0xFF and read 2 bytes → 0x00 (unmapped), then 0x00 from wrapped pointer 0x00. Write to 0x75 → ACKed, no wr_strobe, still reads 0x68.
- Assert rst while driving an ACK low → SDA goes Z within the reset cycle, pwr_mgmt_1 = 0x40; the next transaction decodes normally.
